// File: rtl/aes_cipher_feeder.sv
// aes_cipher_feeder: gathers 32-bit key/text words, launches the AES core and serialises the ciphertext.
module aes_cipher_feeder #(
  parameter int TIMEOUT = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_key,
  input  logic [31:0]  in_data,
  output logic         aes_ld,
  output logic [127:0] aes_key,
  output logic [127:0] aes_text,
  input  logic         aes_done,
  input  logic [127:0] aes_text_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         busy,
  output logic         err,
  input  logic         err_clr
);
  typedef enum logic [1:0] {COLLECT, LOAD, WAIT, OUT} state_t;
  state_t       state;
  logic [1:0]   kcnt, tcnt, ocnt;
  logic [7:0]   wcnt;
  logic         key_ok;
  logic [127:0] res;
  logic         in_fire, out_fire, text_bad, time_out;
  assign in_ready  = state == COLLECT;
  assign busy      = state != COLLECT;
  assign aes_ld    = state == LOAD;
  assign out_valid = state == OUT;
  assign out_last  = out_valid && ocnt == 2'd3;
  assign out_data  = out_valid ? res[{~ocnt, 5'd0} +: 32] : 32'd0;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign text_bad  = in_fire && !in_key && tcnt == 2'd3 && !(key_ok && kcnt == 2'd0);
  assign time_out  = state == WAIT && !aes_done && wcnt == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= COLLECT;
      kcnt     <= '0;
      tcnt     <= '0;
      ocnt     <= '0;
      wcnt     <= '0;
      key_ok   <= 1'b0;
      err      <= 1'b0;
      aes_key  <= '0;
      aes_text <= '0;
      res      <= '0;
    end else begin
      err <= text_bad || time_out || (err && !err_clr);
      case (state)
        COLLECT: if (in_fire) begin
          if (in_key) begin
            // word k lands at bits 127-32k; first word of a key invalidates, fourth validates
            aes_key[{~kcnt, 5'd0} +: 32] <= in_data;
            kcnt   <= kcnt + 2'd1;
            key_ok <= kcnt == 2'd3;
          end else begin
            aes_text[{~tcnt, 5'd0} +: 32] <= in_data;
            tcnt <= tcnt + 2'd1;
            if (tcnt == 2'd3 && key_ok && kcnt == 2'd0) state <= LOAD;
          end
        end
        LOAD: begin
          state <= WAIT;
          wcnt  <= '0;
        end
        WAIT: if (aes_done) begin
          res   <= aes_text_out;
          ocnt  <= '0;
          state <= OUT;
        end else if (time_out) state <= COLLECT;
        else wcnt <= wcnt + 8'd1;
        OUT: if (out_fire) begin
          ocnt <= ocnt + 2'd1;
          if (ocnt == 2'd3) state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_cipher_feeder.sv
// tb_aes_cipher_feeder: directed + randomized checks of the feeder against a word-count reference model.
module tb_aes_cipher_feeder;
  localparam int T = 20;
  localparam int LAT = 9;
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic         clk = 1'b0, rst = 1'b1;
  logic         in_valid = 1'b0, in_ready, in_key = 1'b0;
  logic [31:0]  in_data = '0;
  logic         aes_ld, aes_done = 1'b0;
  logic [127:0] aes_key, aes_text, aes_text_out = '0;
  logic         out_valid, out_ready = 1'b0, out_last, busy, err, err_clr = 1'b0;
  logic [31:0]  out_data;
  aes_cipher_feeder #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
    .in_data(in_data), .aes_ld(aes_ld), .aes_key(aes_key), .aes_text(aes_text),
    .aes_done(aes_done), .aes_text_out(aes_text_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
    .err(err), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  int ld_cnt = 0, exp_ld = 0, nk = 0, cd = 0;
  logic withhold = 1'b0, stale = 1'b0;
  logic [31:0] mkey [4];
  // stand-in cipher: the real FIPS-197 answer for the known vector, a scramble otherwise
  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] p);
    return (k == FK && p == FP) ? FC : k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction
  always @(posedge clk) begin
    aes_done <= 1'b0;
    if (aes_ld) ld_cnt <= ld_cnt + 1;
    if (cd > 0) cd <= cd - 1;
    if (cd == 1 || stale) begin
      aes_done     <= 1'b1;
      aes_text_out <= cipher(aes_key, aes_text);
    end
    if (aes_ld && !withhold) cd <= LAT;
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic k, input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_key   = k;
    in_data  = d;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic send_key(input logic [31:0] d);
    send(1'b1, d);
    mkey[nk % 4] = d;
    nk++;
  endtask
  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clear", err, 0);
  endtask
  task automatic drain(input logic [127:0] ct, input bit rnd);
    int n = 0, idx = 0;
    bit r;
    while (!out_valid && n < LAT + 5) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_rise", out_valid, 1);
    n = 0;
    while (idx < 4 && n < 200) begin
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, ct[(3 - idx) * 32 +: 32]);
      chk("out_last", out_last, idx == 3);
      chk("in_ready_in_out", in_ready, 0);
      r = rnd ? 1'($urandom % 2) : 1'b1;
      out_ready = r;
      @(negedge clk);
      if (r) idx++;
      n++;
    end
    out_ready = 1'b0;
    chk("xfer_count", idx, 4);
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    chk("ld_count", ld_cnt, exp_ld);
  endtask
  // a text block is accepted only when a whole number (>0) of complete keys has been sent
  task automatic run_text(input logic [127:0] p, input bit rnd);
    bit good;
    logic eb;
    logic [127:0] k;
    good = nk > 0 && nk % 4 == 0;
    k = {mkey[0], mkey[1], mkey[2], mkey[3]};
    eb = err;
    for (int i = 0; i < 4; i++) send(1'b0, p[(3 - i) * 32 +: 32]);
    chk("ld_strobe", aes_ld, good);
    chk("err_after_text", err, good ? eb : 1'b1);
    chk("in_ready_after_text", in_ready, !good);
    if (good) begin
      exp_ld++;
      chk("aes_key", aes_key, k);
      chk("aes_text", aes_text, p);
      if (!withhold) drain(cipher(k, p), rnd);
    end else begin
      repeat (3) @(negedge clk);
      chk("no_ld", ld_cnt, exp_ld);
      chk("in_ready_stays", in_ready, 1);
    end
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    int n;
    #1 rst = 1'b0;
    #1;
    chk("rst_aes_ld", aes_ld, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_aes_key", aes_key, 0);
    chk("rst_aes_text", aes_text, 0);
    chk("rst_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    run_text(rnd128(), 0);
    clear_err();
    send_key($urandom);
    send_key($urandom);
    run_text(rnd128(), 0);
    clear_err();
    send_key($urandom);
    send_key($urandom);
    for (int i = 0; i < 4; i++) send_key(FK[(3 - i) * 32 +: 32]);
    run_text(FP, 0);
    run_text(rnd128(), 1);
    for (int b = 0; b < 3; b++) begin
      if ($urandom % 2 == 1) for (int i = 0; i < 4; i++) send_key($urandom);
      run_text(rnd128(), 1);
    end
    send_key($urandom);
    err_clr = 1'b1;
    run_text(rnd128(), 0);
    @(negedge clk);
    chk("err_clr_after_set", err, 0);
    err_clr = 1'b0;
    for (int i = 0; i < 3; i++) send_key($urandom);
    withhold = 1'b1;
    run_text(rnd128(), 0);
    n = 0;
    while (!err && n < 100) begin
      @(negedge clk);
      n++;
      chk("timeout_no_out", out_valid, 0);
    end
    chk("timeout_cycles", n, T + 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_in_ready", in_ready, 1);
    chk("timeout_ld_count", ld_cnt, exp_ld);
    clear_err();
    run_text(rnd128(), 0);
    repeat (3) @(negedge clk);
    chk("mid_wait_busy", busy, 1);
    #1 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_aes_key", aes_key, 0);
    chk("arst_aes_text", aes_text, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_last", out_last, 0);
    @(negedge clk);
    rst = 1'b1;
    nk = 0;
    withhold = 1'b0;
    stale = 1'b1;
    @(negedge clk);
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stale_out_valid", out_valid, 0);
      chk("stale_busy", busy, 0);
    end
    chk("stale_ld_count", ld_cnt, exp_ld);
    for (int i = 0; i < 4; i++) send_key(FK[(3 - i) * 32 +: 32]);
    run_text(FP, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
